// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter: two-digit BCD counter with programmable range, inc/dec, validated set
// and an optional 12/24-hour mode that converts the held value when the mode changes.
module bcd_pair_counter #(
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0,
    parameter bit HAS_12H = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       dec,
    input  logic       set,
    input  logic [3:0] new_tens,
    input  logic [3:0] new_units,
    input  logic       new_pm,
    input  logic       mode12,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       pm,
    output logic       carry,
    output logic       borrow,
    output logic       at_max,
    output logic       at_min,
    output logic       set_err
);
    logic       mode_q, init_done;
    logic       h12, conv, in_rng, set_ok;
    logic       n_pm, n_carry, n_borrow, n_err;
    logic [7:0] v, sv, nv, lo, hi;

    assign h12    = HAS_12H && mode_q;
    assign conv   = HAS_12H && (mode12 != mode_q);
    assign v      = 8'(tens) * 8'd10 + 8'(units);
    assign sv     = 8'(new_tens) * 8'd10 + 8'(new_units);
    assign lo     = h12 ? 8'd1 : 8'(MIN_VAL);
    assign hi     = h12 ? 8'd12 : 8'(MAX_VAL);
    assign in_rng = (v >= lo) && (v <= hi);
    assign set_ok = (new_tens <= 4'd9) && (new_units <= 4'd9) && (sv >= lo) && (sv <= hi);
    assign at_max = (v == hi);
    assign at_min = (v == lo);

    // In 12h mode the wrap 12<->1 is silent; the day boundary sits at 11<->12 instead.
    always_comb begin
        nv       = v;
        n_pm     = pm;
        n_carry  = 1'b0;
        n_borrow = 1'b0;
        n_err    = 1'b0;
        if (!init_done && (MIN_VAL > 0)) begin
            nv = 8'(MIN_VAL);
        end else if (conv) begin
            if (mode12) begin
                n_pm = (v >= 8'd12);
                nv   = (v == 8'd0) ? 8'd12 : (v > 8'd12) ? v - 8'd12 : v;
            end else begin
                n_pm = 1'b0;
                nv   = pm ? ((v == 8'd12) ? 8'd12 : v + 8'd12) : ((v == 8'd12) ? 8'd0 : v);
            end
        end else if (set) begin
            if (set_ok) begin
                nv   = sv;
                n_pm = h12 && new_pm;
            end else begin
                n_err = 1'b1;
            end
        end else if (inc && !dec) begin
            if (!in_rng || (v == hi)) begin
                nv      = lo;
                n_carry = !h12 || !in_rng;
            end else begin
                nv = v + 8'd1;
                if (h12 && (v == 8'd11)) begin
                    n_pm    = !pm;
                    n_carry = pm;
                end
            end
        end else if (dec && !inc) begin
            if (!in_rng || (v == lo)) begin
                nv       = hi;
                n_borrow = !h12 || !in_rng;
            end else begin
                nv = v - 8'd1;
                if (h12 && (v == 8'd12)) begin
                    n_pm     = !pm;
                    n_borrow = !pm;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tens      <= 4'd0;
            units     <= 4'd0;
            pm        <= 1'b0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            set_err   <= 1'b0;
            mode_q    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            tens      <= 4'(nv / 8'd10);
            units     <= 4'(nv % 8'd10);
            pm        <= n_pm;
            carry     <= n_carry;
            borrow    <= n_borrow;
            set_err   <= n_err;
            mode_q    <= mode12;
            init_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bcd_pair_counter.sv
// tb_bcd_pair_counter: three shared-stimulus instances (00..59, 24h/12h hours, 01..31)
// checked each cycle against an hour-of-day style model plus literal spot checks.
module tb_bcd_pair_counter;
    localparam int MX[3]  = '{59, 23, 31};
    localparam int MN[3]  = '{0, 0, 1};
    localparam bit H12[3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0, resetn = 1'b0;
    logic inc = 0, dec = 0, set = 0, new_pm = 0, mode12 = 0;
    logic [3:0] new_tens = 0, new_units = 0;
    logic [2:0][3:0] t_o, u_o;
    logic [2:0] pm_o, c_o, b_o, mx_o, mn_o, e_o;

    int vecs = 0, errs = 0;
    int h[3] = '{0, 0, 0};
    bit mq[3] = '{0, 0, 0}, ini[3] = '{0, 0, 0};
    bit c[3] = '{0, 0, 0}, b[3] = '{0, 0, 0}, e[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bcd_pair_counter #(.MAX_VAL(MX[g]), .MIN_VAL(MN[g]), .HAS_12H(H12[g])) dut (
            .clk(clk), .resetn(resetn), .inc(inc), .dec(dec), .set(set),
            .new_tens(new_tens), .new_units(new_units), .new_pm(new_pm), .mode12(mode12),
            .tens(t_o[g]), .units(u_o[g]), .pm(pm_o[g]), .carry(c_o[g]), .borrow(b_o[g]),
            .at_max(mx_o[g]), .at_min(mn_o[g]), .set_err(e_o[g])
        );
    end

    task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] x);
        vecs++;
        if (a !== x) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, a, x);
        end
    endtask

    // Model keeps the hour of day 0..23 in 12h mode; the 12h display is derived from it.
    function automatic bit m12(int i);
        return H12[i] && mq[i];
    endfunction

    function automatic int disp(int i);
        return m12(i) ? ((h[i] % 12 == 0) ? 12 : h[i] % 12) : h[i];
    endfunction

    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 3; i++) begin
            int d;
            c[i] = 0; b[i] = 0; e[i] = 0;
            if (!resetn) begin
                h[i] = 0; mq[i] = 0; ini[i] = 0;
            end else begin
                if (!ini[i] && MN[i] > 0) h[i] = MN[i];
                else if (H12[i] && mode12 != mq[i]) h[i] = h[i];
                else if (set) begin
                    d = int'(new_tens) * 10 + int'(new_units);
                    if (new_tens <= 9 && new_units <= 9 &&
                        (m12(i) ? (d >= 1 && d <= 12) : (d >= MN[i] && d <= MX[i])))
                        h[i] = m12(i) ? d % 12 + (new_pm ? 12 : 0) : d;
                    else e[i] = 1;
                end else if (inc && !dec) begin
                    if (m12(i)) begin c[i] = (h[i] == 23); h[i] = (h[i] + 1) % 24; end
                    else if (h[i] >= MX[i] || h[i] < MN[i]) begin h[i] = MN[i]; c[i] = 1; end
                    else h[i] = h[i] + 1;
                end else if (dec && !inc) begin
                    if (m12(i)) begin b[i] = (h[i] == 0); h[i] = (h[i] + 23) % 24; end
                    else if (h[i] <= MN[i] || h[i] > MX[i]) begin h[i] = MX[i]; b[i] = 1; end
                    else h[i] = h[i] - 1;
                end
                mq[i] = mode12; ini[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int d;
            d = disp(i);
            cmp($sformatf("dut%0d tens", i), 8'(t_o[i]), 8'(d / 10));
            cmp($sformatf("dut%0d units", i), 8'(u_o[i]), 8'(d % 10));
            cmp($sformatf("dut%0d pm", i), 8'(pm_o[i]), 8'(m12(i) && h[i] >= 12));
            cmp($sformatf("dut%0d carry", i), 8'(c_o[i]), 8'(c[i]));
            cmp($sformatf("dut%0d borrow", i), 8'(b_o[i]), 8'(b[i]));
            cmp($sformatf("dut%0d set_err", i), 8'(e_o[i]), 8'(e[i]));
            cmp($sformatf("dut%0d at_max", i), 8'(mx_o[i]), 8'(d == (m12(i) ? 12 : MX[i])));
            cmp($sformatf("dut%0d at_min", i), 8'(mn_o[i]), 8'(d == (m12(i) ? 1 : MN[i])));
        end
    end

    task automatic cyc(input logic i, input logic d, input logic s, input logic [3:0] t,
                       input logic [3:0] u, input logic p, input logic m);
        inc = i; dec = d; set = s; new_tens = t; new_units = u; new_pm = p; mode12 = m;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        cmp("rst u0 value", {t_o[0], u_o[0]}, 8'h00);
        cmp("rst u2 value", {t_o[2], u_o[2]}, 8'h00);
        cmp("rst u1 pm", 8'(pm_o[1]), 8'd0);
        resetn = 1;
        #1;
        cmp("u2 before first edge", {t_o[2], u_o[2]}, 8'h00);
        #1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("u2 fixup to min", {t_o[2], u_o[2]}, 8'h01);
        cmp("u2 fixup no carry", 8'(c_o[2]), 8'd0);
        cyc(0, 0, 1, 5, 8, 0, 0);
        cmp("u0 set 58", {t_o[0], u_o[0]}, 8'h58);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp("u0 inc 59", {t_o[0], u_o[0]}, 8'h59);
        cmp("u0 at_max", 8'(mx_o[0]), 8'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp("u0 wrap 00", {t_o[0], u_o[0]}, 8'h00);
        cmp("u0 carry pulse", 8'(c_o[0]), 8'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp("u0 inc 01", {t_o[0], u_o[0]}, 8'h01);
        cmp("u0 carry gone", 8'(c_o[0]), 8'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cmp("u0 dec wrap 59", {t_o[0], u_o[0]}, 8'h59);
        cmp("u0 borrow pulse", 8'(b_o[0]), 8'd1);
        cyc(0, 0, 1, 6, 0, 0, 0);
        cmp("u0 set 60 rejected", {t_o[0], u_o[0]}, 8'h59);
        cmp("u0 set_err 60", 8'(e_o[0]), 8'd1);
        cyc(0, 0, 1, 0, 4'hA, 0, 0);
        cmp("u0 set_err units A", 8'(e_o[0]), 8'd1);
        cyc(1, 0, 1, 4, 5, 0, 0);
        cmp("u0 set 45 with inc", {t_o[0], u_o[0]}, 8'h45);
        cmp("u0 set_err clear", 8'(e_o[0]), 8'd0);
        cyc(0, 0, 1, 2, 3, 0, 0);
        repeat (5) cyc(1, 1, 0, 0, 0, 0, 0);
        cmp("u1 inc+dec hold 23", {t_o[1], u_o[1]}, 8'h23);
        cmp("u0 inc+dec hold 23", {t_o[0], u_o[0]}, 8'h23);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("u1 23 to 12h", {t_o[1], u_o[1]}, 8'h11);
        cmp("u1 23 to 12h pm", 8'(pm_o[1]), 8'd1);
        cyc(0, 0, 1, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cmp("u1 11pm inc 12", {t_o[1], u_o[1]}, 8'h12);
        cmp("u1 12am pm", 8'(pm_o[1]), 8'd0);
        cmp("u1 11pm carry", 8'(c_o[1]), 8'd1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cmp("u1 12 inc 01", {t_o[1], u_o[1]}, 8'h01);
        cmp("u1 12 inc no carry", 8'(c_o[1]), 8'd0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cmp("u1 01 dec 12", {t_o[1], u_o[1]}, 8'h12);
        cmp("u1 01 dec no borrow", 8'(b_o[1]), 8'd0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cmp("u1 12am dec 11", {t_o[1], u_o[1]}, 8'h11);
        cmp("u1 11pm pm", 8'(pm_o[1]), 8'd1);
        cmp("u1 12am borrow", 8'(b_o[1]), 8'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("u1 11pm to 24h", {t_o[1], u_o[1]}, 8'h23);
        cyc(0, 0, 1, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("u1 17 to 05", {t_o[1], u_o[1]}, 8'h05);
        cmp("u1 17 to 05 pm", 8'(pm_o[1]), 8'd1);
        cmp("u1 conv no carry", 8'(c_o[1]), 8'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("u1 05pm to 17", {t_o[1], u_o[1]}, 8'h17);
        cmp("u1 24h pm clear", 8'(pm_o[1]), 8'd0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("u1 00 to 12am", {t_o[1], u_o[1]}, 8'h12);
        cmp("u1 12am pm 0", 8'(pm_o[1]), 8'd0);
        cyc(0, 0, 1, 0, 5, 0, 0);
        cmp("u1 12am to 00 set ignored", {t_o[1], u_o[1]}, 8'h00);
        cyc(0, 0, 1, 3, 1, 0, 0);
        cmp("u2 set 31", {t_o[2], u_o[2]}, 8'h31);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp("u2 wrap to 01", {t_o[2], u_o[2]}, 8'h01);
        cmp("u2 carry pulse", 8'(c_o[2]), 8'd1);
        resetn = 0;
        #1;
        cmp("u2 async rst value", {t_o[2], u_o[2]}, 8'h00);
        cmp("u2 async rst carry", 8'(c_o[2]), 8'd0);
        @(posedge clk);
        #2;
        resetn = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("u2 refix to 01", {t_o[2], u_o[2]}, 8'h01);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bcd_pair_counter.md
Name: bcd_pair_counter

Overview:
- Parametrised two-digit BCD counter: units and tens digits, programmable range, inc/dec, validated parallel set, registered carry/borrow pulses.
- Next generation of the per-digit hour/minute/second registers in the alarm clock.
- One instance replaces a tens/units register pair plus its external wrap glue.
- Optional 12/24-hour mode with on-the-fly value conversion and AM/PM flag.

Parameters:
- MAX_VAL, 59, top of count range (decimal, 1..99).
- MIN_VAL, 0, bottom of count range (decimal, must be < MAX_VAL).
- HAS_12H, 0, 1 enables the mode12 logic and the pm flag. Legal only with MAX_VAL=23, MIN_VAL=0. When 0, mode12 is ignored and pm is tied to 0.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inc  in  1  count up one step this cycle
- dec  in  1  count down one step this cycle
- set  in  1  load new_tens/new_units this cycle
- new_tens  in  4  BCD tens digit to load
- new_units  in  4  BCD units digit to load
- new_pm  in  1  pm value loaded with set in 12h mode
- mode12  in  1  1 = 12-hour display range 1..12 (HAS_12H only)
- tens  out  4  BCD tens digit
- units  out  4  BCD units digit
- pm  out  1  PM flag (12h mode only, else 0)
- carry  out  1  one-cycle pulse after an up-wrap
- borrow  out  1  one-cycle pulse after a down-wrap
- at_max  out  1  combinational: value equals current range top
- at_min  out  1  combinational: value equals current range bottom
- set_err  out  1  one-cycle pulse after a rejected set

Behaviour:
- Reset (resetn=0, asynchronous): tens=0, units=0, pm=0, carry=0, borrow=0, set_err=0, mode_q=0.
- Reset value is 00 regardless of MIN_VAL. When MIN_VAL>0, the first edge after reset forces MIN_VAL (treated as an in-range fix-up, no pulses).
- Priority per edge: mode conversion > set > inc/dec.
- inc and dec both high: no change.
- All state changes occur on the rising clk edge. carry, borrow and set_err are registered and high for exactly the cycle following the causing edge.
- Range:
  - 24h / non-HAS_12H: MIN_VAL..MAX_VAL.
  - 12h: 1..12.
- Inc (24h):
  - units<9: units+1.
  - units=9: units=0, tens+1.
  - at MAX_VAL: load MIN_VAL, assert carry.
- Dec (24h):
  - units>0: units-1.
  - units=0: units=9, tens-1.
  - at MIN_VAL: load MAX_VAL, assert borrow.
- Inc (12h):
  - 11→12 toggles pm. If pm was 1 (11PM→12AM), also assert carry.
  - 12→1: no pm change, no carry.
- Dec (12h):
  - 12→11 toggles pm. If pm was 0 (12AM→11PM), also assert borrow.
  - 1→12: no pm change, no borrow.
- Set:
  - Accepted only if both digits ≤9 and the value is in the current range. Accepted value loads; pm loads new_pm in 12h mode, else pm=0.
  - Rejected: value unchanged, set_err pulses.
  - inc/dec in the same cycle as set are discarded, accepted or not.
- Mode conversion (HAS_12H=1): mode_q registers mode12 each edge. A difference between mode12 and mode_q triggers conversion at that edge; set/inc/dec that cycle are discarded.
  - 24→12: 0→12 pm=0; 1..11 unchanged pm=0; 12→12 pm=1; 13..23→v-12 pm=1.
  - 12→24: 12AM→0; 12PM→12; 1..11 AM unchanged; 1..11 PM→v+12; pm=0 afterwards.
  - No carry or borrow from conversion.
- Out-of-range state (only reachable via parameter misuse): the next inc loads MIN_VAL with carry.
- Reset asserted mid-pulse clears the pulse immediately.

Test Plan:
- MAX_VAL=59: set 5/8, then inc ×3 → 59, 00 with carry high exactly one cycle, then 01. Dec from 00 → 59 with borrow one cycle.
- MAX_VAL=59: set tens=6 units=0 → set_err one cycle, value unchanged. Set units=0xA → set_err. Set 4/5 with inc high → 45, no inc applied.
- HAS_12H, mode12=1: set 11 pm=1, inc → 12 pm=0 carry=1. Inc → 01 pm=0 carry=0. Dec twice → 12 pm=0, then 11 pm=1 with borrow.
- HAS_12H: 24h value 17, raise mode12 → next edge 05 pm=1, no carry. Lower mode12 → 17 pm=0. Value 00 → 12 pm=0 and back to 00.
- inc and dec held high together for 5 cycles from 23 → stays 23, no pulses.
- MIN_VAL=1, MAX_VAL=31: reset then release → 00 becomes 01 at first edge. Inc from 31 → 01 with carry. Assert resetn=0 asynchronously between edges → outputs 00 and pulses 0 immediately.
